// File: rtl/lmring_inj.sv
// lmring_inj: head-of-ring injector; expands AXI-side burst commands into one ring beat per 32-byte line.
// Latency: accepted command -> first out_nemp is 2 cycles; afterwards 1 beat/cycle while out_ful is low.
// Backpressure: out_ful freezes the output slot; wd_ready and cmd_ready drop until the slot/FSM can move.
// Optional feature macro: LMRING_INJ_PERF_EN (adds perf_beats/perf_stall saturating counters).
module lmring_inj #(
    parameter int ADDR_W = 31,
    parameter int DATA_W = 256,
    parameter int DM_W   = DATA_W / 8,
    parameter int LEN_W  = 8,
    parameter int SQ_W   = 16
) (
    input  logic              ACLK,
    input  logic              RSTN,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [2:0]        cmd_ty,
    input  logic [1:0]        cmd_col,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    // write-data channel
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    input  logic [DM_W-1:0]   wd_strb,
    // ring output slot
    output logic              out_nemp,
    output logic              out_rw,
    output logic [2:0]        out_ty,
    output logic [1:0]        out_col,
    output logic [SQ_W-1:0]   out_sq,
    output logic              out_av,
    output logic [ADDR_W-1:0] out_a,
    output logic [DM_W-1:0]   out_dm,
    output logic [DATA_W-1:0] out_d,
    input  logic              out_ful,
    // status
    output logic              done,
    output logic              busy
`ifdef LMRING_INJ_PERF_EN
    ,
    output logic [31:0]       perf_beats,
    output logic [31:0]       perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_LAST = 2'd3
    } state_t;

    // Clearing the low five bits and adding one line gives the next line base.
    localparam logic [ADDR_W-1:0] LINE_MASK  = ~ADDR_W'(31);
    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(32);

    // control state
    state_t              state_q, state_d;
    logic [2:0]          ty_q, ty_d;
    logic [1:0]          col_q, col_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic                done_q, done_d;
    // Holds cmd_ready low for the first cycle after reset release.
    logic                rdy_en_q;

    // output slot
    logic                nemp_q, nemp_d;
    logic                srw_q, srw_d;
    logic [2:0]          sty_q, sty_d;
    logic [1:0]          scol_q, scol_d;
    logic [SQ_W-1:0]     ssq_q, ssq_d;
    logic                sav_q, sav_d;
    logic [ADDR_W-1:0]   sa_q, sa_d;
    logic [DM_W-1:0]     sdm_q, sdm_d;
    logic [DATA_W-1:0]   sd_q, sd_d;

    // combinational helpers
    logic                fire;
    logic                loadable;
    logic                load;
    logic                ld_rw;
    logic [DM_W-1:0]     ld_dm;
    logic [DATA_W-1:0]   ld_d;
    logic                cmd_ready_c;
    logic                wd_ready_c;

    assign fire     = nemp_q && !out_ful;
    assign loadable = !nemp_q || fire;

    // State and slot registers; reset discards any pending beats.
    always_ff @(posedge ACLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= S_IDLE;
            ty_q     <= '0;
            col_q    <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            beat_q   <= '0;
            done_q   <= 1'b0;
            rdy_en_q <= 1'b0;
            nemp_q   <= 1'b0;
            srw_q    <= 1'b0;
            sty_q    <= '0;
            scol_q   <= '0;
            ssq_q    <= '0;
            sav_q    <= 1'b0;
            sa_q     <= '0;
            sdm_q    <= '0;
            sd_q     <= '0;
        end else begin
            state_q  <= state_d;
            ty_q     <= ty_d;
            col_q    <= col_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            done_q   <= done_d;
            rdy_en_q <= 1'b1;
            nemp_q   <= nemp_d;
            srw_q    <= srw_d;
            sty_q    <= sty_d;
            scol_q   <= scol_d;
            ssq_q    <= ssq_d;
            sav_q    <= sav_d;
            sa_q     <= sa_d;
            sdm_q    <= sdm_d;
            sd_q     <= sd_d;
        end
    end

    // Next-state, slot load and handshake decode.
    always_comb begin
        state_d     = state_q;
        ty_d        = ty_q;
        col_d       = col_q;
        len_d       = len_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        done_d      = 1'b0;
        cmd_ready_c = 1'b0;
        wd_ready_c  = 1'b0;
        load        = 1'b0;
        ld_rw       = 1'b0;
        ld_dm       = '1;
        ld_d        = '0;

        // A departing beat empties the slot unless a new one is loaded below.
        nemp_d = nemp_q && !fire;
        srw_d  = srw_q;
        sty_d  = sty_q;
        scol_d = scol_q;
        ssq_d  = ssq_q;
        sav_d  = sav_q;
        sa_d   = sa_q;
        sdm_d  = sdm_q;
        sd_d   = sd_q;

        case (state_q)
            S_IDLE: begin
                cmd_ready_c = rdy_en_q;
                if (cmd_valid && rdy_en_q) begin
                    ty_d    = cmd_ty;
                    col_d   = cmd_col;
                    // Register/conf/lddmq ops are always a single beat.
                    len_d   = (cmd_ty < 3'd4) ? '0 : cmd_len;
                    addr_d  = cmd_addr;
                    beat_d  = '0;
                    state_d = cmd_rw ? S_WR : S_RD;
                end
            end
            S_RD: begin
                if (loadable) begin
                    load  = 1'b1;
                    ld_rw = 1'b0;
                    ld_dm = '1;
                    ld_d  = '0;
                end
            end
            S_WR: begin
                wd_ready_c = loadable;
                if (wd_valid && loadable) begin
                    load  = 1'b1;
                    ld_rw = 1'b1;
                    ld_dm = wd_strb;
                    ld_d  = wd_data;
                end
            end
            S_LAST: begin
                if (fire) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            nemp_d = 1'b1;
            srw_d  = ld_rw;
            sty_d  = ty_q;
            scol_d = col_q;
            ssq_d  = SQ_W'(beat_q);
            sav_d  = 1'b0;
            // First beat keeps the low address bits; later beats are line aligned.
            sa_d   = addr_q;
            sdm_d  = ld_dm;
            sd_d   = ld_d;
            beat_d = beat_q + LEN_W'(1);
            addr_d = (addr_q & LINE_MASK) + LINE_BYTES;
            if (beat_q == len_q) begin
                state_d = S_LAST;
            end
        end
    end

    assign cmd_ready = cmd_ready_c;
    assign wd_ready  = wd_ready_c;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE) || nemp_q;

    assign out_nemp  = nemp_q;
    assign out_rw    = srw_q;
    assign out_ty    = sty_q;
    assign out_col   = scol_q;
    assign out_sq    = ssq_q;
    assign out_av    = sav_q;
    assign out_a     = sa_q;
    assign out_dm    = sdm_q;
    assign out_d     = sd_q;

`ifdef LMRING_INJ_PERF_EN
    logic [31:0] perf_beats_q, perf_beats_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating beat and stall counters.
    always_comb begin
        perf_beats_d = perf_beats_q;
        perf_stall_d = perf_stall_q;
        if (fire && (perf_beats_q != 32'hFFFF_FFFF)) begin
            perf_beats_d = perf_beats_q + 32'd1;
        end
        if (nemp_q && out_ful && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge ACLK or negedge RSTN) begin
        if (!RSTN) begin
            perf_beats_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_beats_q <= perf_beats_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_beats = perf_beats_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_lmring_inj.sv
// tb_lmring_inj: directed bench for lmring_inj.
// Inputs change 1 time unit after the rising edge; outputs are checked there as well.
// Expected values are hand-derived constants per directed step.
module tb_lmring_inj;

    localparam int ADDR_W = 31;
    localparam int DATA_W = 256;
    localparam int DM_W   = 32;
    localparam int LEN_W  = 8;
    localparam int SQ_W   = 16;

    logic              ACLK;
    logic              RSTN;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [2:0]        cmd_ty;
    logic [1:0]        cmd_col;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wd_valid;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data;
    logic [DM_W-1:0]   wd_strb;
    logic              out_nemp;
    logic              out_rw;
    logic [2:0]        out_ty;
    logic [1:0]        out_col;
    logic [SQ_W-1:0]   out_sq;
    logic              out_av;
    logic [ADDR_W-1:0] out_a;
    logic [DM_W-1:0]   out_dm;
    logic [DATA_W-1:0] out_d;
    logic              out_ful;
    logic              done;
    logic              busy;
`ifdef LMRING_INJ_PERF_EN
    logic [31:0]       perf_beats;
    logic [31:0]       perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
    logic [ADDR_W-1:0] rd_addr [4];

    lmring_inj #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DM_W(DM_W), .LEN_W(LEN_W), .SQ_W(SQ_W)
    ) dut (
        .ACLK(ACLK), .RSTN(RSTN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_ty(cmd_ty),
        .cmd_col(cmd_col), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .out_nemp(out_nemp), .out_rw(out_rw), .out_ty(out_ty), .out_col(out_col),
        .out_sq(out_sq), .out_av(out_av), .out_a(out_a), .out_dm(out_dm), .out_d(out_d),
        .out_ful(out_ful), .done(done), .busy(busy)
`ifdef LMRING_INJ_PERF_EN
        , .perf_beats(perf_beats), .perf_stall(perf_stall)
`endif
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic rw, input logic [2:0] ty, input logic [1:0] col,
                            input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        cmd_rw    = rw;
        cmd_ty    = ty;
        cmd_col   = col;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        #1;
        chk("cmd_ready_before_cmd", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        RSTN = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_ty = '0; cmd_col = '0;
        cmd_addr = '0; cmd_len = '0; wd_valid = 1'b0; wd_data = '0; wd_strb = '0; out_ful = 1'b0;
        d0 = {8{32'hA5A5_0001}};
        d1 = {8{32'h5A5A_0002}};
        rd_addr[0] = 31'h0000_1004;
        rd_addr[1] = 31'h0000_1020;
        rd_addr[2] = 31'h0000_1040;
        rd_addr[3] = 31'h0000_1060;

        // ---- reset state ----
        tick();
        chk("rst_nemp", out_nemp, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_wd_ready", wd_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_a", out_a, 0);
        chk("rst_sq", out_sq, 0);
        chk("rst_dm", out_dm, 0);
        tick();
        RSTN = 1'b1;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // ---- read burst, 4 beats, no backpressure ----
        send_cmd(1'b0, 3'd4, 2'd2, 31'h0000_1004, 8'd3);
        chk("rd_lat1_nemp", out_nemp, 0);
        chk("rd_cmd_ready_busy", cmd_ready, 0);
        chk("rd_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rd_nemp", out_nemp, 1);
            chk("rd_a", out_a, rd_addr[i]);
            chk("rd_sq", out_sq, i);
            chk("rd_dm", out_dm, 32'hFFFF_FFFF);
            chk("rd_rw", out_rw, 0);
            chk("rd_ty", out_ty, 4);
            chk("rd_col", out_col, 2);
            chk("rd_av", out_av, 0);
            chk("rd_d", out_d, 0);
            chk("rd_done_early", done, 0);
        end
        tick();
        chk("rd_done", done, 1);
        chk("rd_nemp_end", out_nemp, 0);
        tick();
        chk("rd_done_pulse", done, 0);
        chk("rd_idle_ready", cmd_ready, 1);
        chk("rd_idle_busy", busy, 0);

        // ---- write burst, 2 beats, 5-cycle stall on beat 0 ----
        wd_valid = 1'b1; wd_data = d0; wd_strb = 32'h0000_00FF; out_ful = 1'b1;
        send_cmd(1'b1, 3'd4, 2'd1, 31'h0000_2000, 8'd1);
        chk("wr_wd_ready_empty", wd_ready, 1);
        tick();
        wd_data = d1; wd_strb = 32'hFFFF_0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("wr_stall_nemp", out_nemp, 1);
            chk("wr_stall_dm", out_dm, 32'h0000_00FF);
            chk("wr_stall_d", out_d, d0);
            chk("wr_stall_a", out_a, 31'h0000_2000);
            chk("wr_stall_sq", out_sq, 0);
            chk("wr_stall_wd_ready", wd_ready, 0);
            chk("wr_stall_done", done, 0);
            if (i < 4) tick();
        end
        out_ful = 1'b0;
        #1;
        chk("wr_release_wd_ready", wd_ready, 1);
        tick();
        wd_valid = 1'b0;
        chk("wr_b1_nemp", out_nemp, 1);
        chk("wr_b1_rw", out_rw, 1);
        chk("wr_b1_dm", out_dm, 32'hFFFF_0000);
        chk("wr_b1_d", out_d, d1);
        chk("wr_b1_sq", out_sq, 1);
        chk("wr_b1_a", out_a, 31'h0000_2020);
        chk("wr_b1_col", out_col, 1);
        chk("wr_b1_done", done, 0);
        tick();
        chk("wr_done", done, 1);
        chk("wr_nemp_end", out_nemp, 0);
        tick();
        chk("wr_done_once", done, 0);

        // ---- write starvation: wd_valid low for 3 cycles mid-burst ----
        wd_valid = 1'b1; wd_data = d0; wd_strb = 32'h0F0F_0F0F;
        send_cmd(1'b1, 3'd4, 2'd0, 31'h0000_3000, 8'd3);
        tick();
        chk("st_b0_sq", out_sq, 0);
        chk("st_b0_a", out_a, 31'h0000_3000);
        tick();
        chk("st_b1_sq", out_sq, 1);
        chk("st_b1_a", out_a, 31'h0000_3020);
        wd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_gap_nemp", out_nemp, 0);
            chk("st_gap_done", done, 0);
        end
        wd_valid = 1'b1;
        tick();
        chk("st_b2_nemp", out_nemp, 1);
        chk("st_b2_sq", out_sq, 2);
        chk("st_b2_a", out_a, 31'h0000_3040);
        tick();
        wd_valid = 1'b0;
        chk("st_b3_sq", out_sq, 3);
        chk("st_b3_a", out_a, 31'h0000_3060);
        tick();
        chk("st_done", done, 1);
        chk("st_nemp_end", out_nemp, 0);
        tick();

        // ---- register op: ty=1 len=7 collapses to one beat ----
        send_cmd(1'b0, 3'd1, 2'd3, 31'h0000_5013, 8'd7);
        tick();
        chk("reg_nemp", out_nemp, 1);
        chk("reg_sq", out_sq, 0);
        chk("reg_a", out_a, 31'h0000_5013);
        chk("reg_ty", out_ty, 1);
        chk("reg_col", out_col, 3);
        tick();
        chk("reg_done", done, 1);
        chk("reg_single_beat", out_nemp, 0);
        tick();
        chk("reg_idle_nemp", out_nemp, 0);
        chk("reg_idle_busy", busy, 0);

        // ---- address wrap ----
        send_cmd(1'b0, 3'd4, 2'd0, 31'h7FFF_FFE0, 8'd1);
        tick();
        chk("wrap_b0_a", out_a, 31'h7FFF_FFE0);
        tick();
        chk("wrap_b1_a", out_a, 31'h0000_0000);
        chk("wrap_b1_sq", out_sq, 1);
        tick();
        chk("wrap_done", done, 1);
        tick();

        // ---- reset mid-burst ----
        send_cmd(1'b0, 3'd4, 2'd0, 31'h0000_6000, 8'd3);
        tick();
        tick();
        tick();
        chk("mid_b2_sq", out_sq, 2);
        RSTN = 1'b0;
        #1;
        chk("mid_rst_nemp", out_nemp, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sq", out_sq, 0);
        tick();
        chk("mid_rst_done_held", done, 0);
        RSTN = 1'b1;
        tick();
        chk("mid_post_done", done, 0);
        send_cmd(1'b0, 3'd4, 2'd1, 31'h0000_7000, 8'd0);
        tick();
        chk("mid_new_nemp", out_nemp, 1);
        chk("mid_new_sq", out_sq, 0);
        chk("mid_new_a", out_a, 31'h0000_7000);
        tick();
        chk("mid_new_done", done, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
